tron_mem_port: RTL and testbench



---
 rtl/tron_mem_pkg.sv | 21 ++
 rtl/tron_mem_port_if.sv | 45 ++++
 rtl/tron_spram.sv | 28 ++
 rtl/tron_mem_port.sv | 152 +++++++++++++++
 tb/tb_tron_mem_port.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tron_mem_pkg.sv
// Shared definitions for the Tron memory responder: FSM state type,
// default geometry and the address range helper.
// Optional feature macro used by the responder: TRON_MEM_RANGE_CHK_EN.
package tron_mem_pkg;

   localparam int ADDR_W_DEF = 10;   // RAM word-address width
   localparam int DATA_W_DEF = 16;   // word width
   localparam int BUS_ADDR_W = 16;   // core address bus width

   typedef enum logic {
      LOAD = 1'b0,
      RUN  = 1'b1
   } state_t;

   // True when every address bit above the RAM index is zero.
   function automatic logic addr_in_range(input logic [BUS_ADDR_W-1:0] addr,
                                          input int addr_w);
      return ((addr >> addr_w) == '0);
   endfunction

endpackage

// File: rtl/tron_mem_port_if.sv
// Core/boot-loader side bus of the Tron memory responder.
// master = core + boot streamer, slave = tron_mem_port.
interface tron_mem_port_if #(
   parameter int DATA_W = 16
);
   // boot-load stream
   logic              ld_valid;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_ready;
   logic              core_hold;
   // instruction fetch
   logic              if_req;
   logic [15:0]       if_addr;
   logic              if_stall;
   logic              if_valid;
   logic [DATA_W-1:0] instruction;
   // data load/store
   logic              d_req;
   logic              d_we;
   logic [15:0]       d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_valid;
   logic [DATA_W-1:0] d_rdata;
   // sticky out-of-range flag
   logic              oob_err;

   modport master (
      output ld_valid, ld_data, ld_last,
      output if_req, if_addr,
      output d_req, d_we, d_addr, d_wdata,
      input  ld_ready, core_hold,
      input  if_stall, if_valid, instruction,
      input  d_valid, d_rdata, oob_err
   );

   modport slave (
      input  ld_valid, ld_data, ld_last,
      input  if_req, if_addr,
      input  d_req, d_we, d_addr, d_wdata,
      output ld_ready, core_hold,
      output if_stall, if_valid, instruction,
      output d_valid, d_rdata, oob_err
   );
endinterface

// File: rtl/tron_spram.sv
// Single-port synchronous word RAM with registered read data.
// The array and the read register are deliberately not reset so that
// contents survive a reset of the surrounding logic.
module tron_spram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Write port and registered read of the addressed word.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      rdata_q <= mem[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/tron_mem_port.sv
// Tron memory responder: boot-loads a program image into a single-port RAM
// while holding the core, then serves fetches and data accesses with one
// cycle read latency. Data accesses win the RAM port; fetches are stalled.
// Optional feature macro: TRON_MEM_RANGE_CHK_EN (flag and squash accesses
// whose upper address bits are non-zero instead of aliasing them).
module tron_mem_port
   import tron_mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   tron_mem_port_if.slave   bus
);

   localparam logic [ADDR_W-1:0] LD_CNT_MAX = '1;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d;

   logic              run;
   logic              d_grant, f_grant;
   logic              d_in_range, f_in_range;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   logic              if_valid_q, d_valid_q;
   logic              rd_oob_q;
   logic [DATA_W-1:0] instr_hold_q, d_hold_q;
   logic [DATA_W-1:0] rdata_now;

   // Upper address bits only matter when the range check is built in.
   logic              unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr, bus.d_addr};

`ifdef TRON_MEM_RANGE_CHK_EN
   assign d_in_range = addr_in_range(bus.d_addr, ADDR_W);
   assign f_in_range = addr_in_range(bus.if_addr, ADDR_W);
`else
   assign d_in_range = 1'b1;
   assign f_in_range = 1'b1;
`endif

   assign run     = (state_q == RUN);
   assign d_grant = run & bus.d_req;
   assign f_grant = run & bus.if_req & ~bus.d_req;

   assign bus.ld_ready  = ~run;
   assign bus.core_hold = ~run;
   assign bus.if_stall  = ~run | (bus.if_req & bus.d_req);

   // State and load counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= LOAD;
         ld_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         ld_cnt_q <= ld_cnt_d;
      end
   end

   // Boot-load sequencing: leave LOAD on the last word or when the RAM is full.
   always_comb begin
      state_d  = state_q;
      ld_cnt_d = ld_cnt_q;
      if ((state_q == LOAD) && bus.ld_valid) begin
         if (bus.ld_last || (ld_cnt_q == LD_CNT_MAX)) begin
            state_d = RUN;
         end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
         end
      end
   end

   // RAM port steering: loader in LOAD, otherwise data access before fetch.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = bus.if_addr[ADDR_W-1:0];
      ram_wdata = bus.d_wdata;
      if (!run) begin
         ram_we    = bus.ld_valid;
         ram_addr  = ld_cnt_q;
         ram_wdata = bus.ld_data;
      end else if (bus.d_req) begin
         ram_we   = bus.d_we & d_in_range;
         ram_addr = bus.d_addr[ADDR_W-1:0];
      end
   end

   tron_spram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (ram_addr),
      .wdata_i (ram_wdata),
      .rdata_o (ram_rdata)
   );

   // Squashed out-of-range reads present zero instead of RAM data.
   assign rdata_now = rd_oob_q ? '0 : ram_rdata;

   // Response valids track grants; hold registers keep the last delivered words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_valid_q   <= 1'b0;
         d_valid_q    <= 1'b0;
         rd_oob_q     <= 1'b0;
         instr_hold_q <= '0;
         d_hold_q     <= '0;
      end else begin
         if_valid_q <= f_grant;
         d_valid_q  <= d_grant & ~bus.d_we;
         rd_oob_q   <= bus.d_req ? ~d_in_range : ~f_in_range;
         if (if_valid_q) begin
            instr_hold_q <= rdata_now;
         end
         if (d_valid_q) begin
            d_hold_q <= rdata_now;
         end
      end
   end

   assign bus.if_valid    = if_valid_q;
   assign bus.d_valid     = d_valid_q;
   assign bus.instruction = if_valid_q ? rdata_now : instr_hold_q;
   assign bus.d_rdata     = d_valid_q ? rdata_now : d_hold_q;

`ifdef TRON_MEM_RANGE_CHK_EN
   logic oob_q;

   // Sticky flag for any granted access outside the RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         oob_q <= 1'b0;
      end else if ((d_grant & ~d_in_range) | (f_grant & ~f_in_range)) begin
         oob_q <= 1'b1;
      end
   end

   assign bus.oob_err = oob_q;
`else
   assign bus.oob_err = 1'b0;
`endif

endmodule

// File: tb/tb_tron_mem_port.sv
// Bench for tron_mem_port: a per-cycle behavioural model of the 1K-word
// responder checked every cycle, plus directed literal checks, and a second
// 16-word instance for the RAM-full boot-load case.
module tb_tron_mem_port;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tron_mem_port_if #(.DATA_W(16)) bus  ();
   tron_mem_port_if #(.DATA_W(16)) sbus ();

   tron_mem_port #(.ADDR_W(10), .DATA_W(16)) u_dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   tron_mem_port #(.ADDR_W(4), .DATA_W(16)) u_small (
      .clk   (clk),
      .reset (rst),
      .bus   (sbus)
   );

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of the 1K-word responder ----------
   logic [15:0] m_mem [1024];
   logic        m_load, m_ifv, m_dv, m_oob;
   int          m_cnt;
   logic [15:0] m_instr, m_drd;

   function automatic logic m_ok(input logic [15:0] a);
`ifdef TRON_MEM_RANGE_CHK_EN
      return a < 16'd1024;
`else
      return 1'b1;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_load <= 1'b1; m_cnt <= 0; m_ifv <= 1'b0; m_dv <= 1'b0;
         m_oob <= 1'b0; m_instr <= '0; m_drd <= '0;
      end else begin
         m_ifv <= 1'b0;
         m_dv  <= 1'b0;
         if (m_load) begin
            if (bus.ld_valid) begin
               m_mem[m_cnt] <= bus.ld_data;
               if (bus.ld_last || m_cnt == 1023) m_load <= 1'b0;
               else m_cnt <= m_cnt + 1;
            end
         end else if (bus.d_req) begin
            if (!m_ok(bus.d_addr)) m_oob <= 1'b1;
            if (bus.d_we) begin
               if (m_ok(bus.d_addr)) m_mem[bus.d_addr % 1024] <= bus.d_wdata;
            end else begin
               m_dv  <= 1'b1;
               m_drd <= m_ok(bus.d_addr) ? m_mem[bus.d_addr % 1024] : 16'h0000;
            end
         end else if (bus.if_req) begin
            if (!m_ok(bus.if_addr)) m_oob <= 1'b1;
            m_ifv   <= 1'b1;
            m_instr <= m_ok(bus.if_addr) ? m_mem[bus.if_addr % 1024] : 16'h0000;
         end
      end
   end

   // Compare every output of the main instance against the model each cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ld_ready",    bus.ld_ready,    m_load);
         chk("core_hold",   bus.core_hold,   m_load);
         chk("if_stall",    bus.if_stall,    m_load | (bus.if_req & bus.d_req));
         chk("if_valid",    bus.if_valid,    m_ifv);
         chk("d_valid",     bus.d_valid,     m_dv);
         chk("instruction", bus.instruction, m_instr);
         chk("d_rdata",     bus.d_rdata,     m_drd);
         chk("oob_err",     bus.oob_err,     m_oob);
      end
   end

   // ---------------- stimulus helpers ------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [15:0] d, input logic last);
      bus.ld_valid = 1'b1; bus.ld_data = d; bus.ld_last = last;
      tick();
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
   endtask

   initial begin
      bus.ld_valid = 0; bus.ld_data = 0; bus.ld_last = 0;
      bus.if_req = 0; bus.if_addr = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
      sbus.ld_valid = 0; sbus.ld_data = 0; sbus.ld_last = 0;
      sbus.if_req = 0; sbus.if_addr = 0;
      sbus.d_req = 0; sbus.d_we = 0; sbus.d_addr = 0; sbus.d_wdata = 0;

      // reset state
      #2 rst = 1'b1;
      #1 chk_en = 1'b1;
      @(negedge clk);
      chk("rst_core_hold", bus.core_hold, 1);
      chk("rst_if_stall", bus.if_stall, 1);
      chk("rst_instruction", bus.instruction, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      @(posedge clk); #1 rst = 1'b0;
      $display("reset released");

      // boot load of three words, then fetch addr 1 in the release cycle
      ld(16'h1111, 0);
      ld(16'h2222, 0);
      ld(16'h3333, 1);
      bus.if_req = 1; bus.if_addr = 16'd1;
      @(negedge clk);
      chk("boot_hold_fall", bus.core_hold, 0);
      chk("boot_ld_ready", bus.ld_ready, 0);
      chk("boot_first_fetch_grant", bus.if_stall, 0);
      tick(); bus.if_req = 0;
      @(negedge clk);
      chk("boot_fetch_valid", bus.if_valid, 1);
      chk("boot_fetch_data", bus.instruction, 16'h2222);
      $display("boot load + fetch addr 1 -> %h", bus.instruction);
      tick();

      // collision: data read wins, fetch retried next cycle
      bus.if_req = 1; bus.if_addr = 16'd0;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'd2;
      @(negedge clk);
      chk("coll_stall", bus.if_stall, 1);
      tick(); bus.d_req = 0;
      @(negedge clk);
      chk("coll_d_valid", bus.d_valid, 1);
      chk("coll_d_data", bus.d_rdata, 16'h3333);
      chk("coll_retry_grant", bus.if_stall, 0);
      tick(); bus.if_req = 0;
      @(negedge clk);
      chk("coll_fetch_data", bus.instruction, 16'h1111);
      chk("coll_d_hold", bus.d_rdata, 16'h3333);
      $display("collision: d=%h then i=%h", bus.d_rdata, bus.instruction);
      tick();

      // write then immediate read of the same address
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'd5; bus.d_wdata = 16'hBEEF;
      tick(); bus.d_we = 0;
      @(negedge clk);
      chk("wr_no_pulse", bus.d_valid, 0);
      tick(); bus.d_req = 0;
      @(negedge clk);
      chk("raw_data", bus.d_rdata, 16'hBEEF);
      $display("write/read addr 5 -> %h", bus.d_rdata);
      tick();

      // back-to-back fetches, one per cycle
      for (int i = 0; i < 3; i++) begin
         bus.if_req = 1; bus.if_addr = 16'(i);
         tick();
      end
      bus.if_req = 0;
      @(negedge clk);
      chk("stream_last", bus.instruction, 16'h3333);
      $display("fetch stream 0..2 ends with %h", bus.instruction);
      tick();

      // upper address bits: range check or aliasing
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h0400;
      tick(); bus.d_req = 0;
      @(negedge clk);
`ifdef TRON_MEM_RANGE_CHK_EN
      chk("oob_rd_zero", bus.d_rdata, 0);
      chk("oob_flag", bus.oob_err, 1);
`else
      chk("alias_rd", bus.d_rdata, 16'h1111);
      chk("no_oob_flag", bus.oob_err, 0);
`endif
      tick();
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 16'h0405; bus.d_wdata = 16'hDEAD;
      tick(); bus.d_we = 0; bus.d_addr = 16'd5;
      tick(); bus.d_req = 0;
      @(negedge clk);
`ifdef TRON_MEM_RANGE_CHK_EN
      chk("oob_wr_dropped", bus.d_rdata, 16'hBEEF);
      chk("oob_sticky", bus.oob_err, 1);
`else
      chk("alias_wr", bus.d_rdata, 16'hDEAD);
`endif
      $display("upper-bit access: rd5=%h oob=%b", bus.d_rdata, bus.oob_err);
      tick();

      // small instance: fill all 16 words without ld_last
      for (int i = 0; i < 16; i++) begin
         sbus.ld_valid = 1; sbus.ld_data = 16'hA000 + 16'(i);
         @(negedge clk);
         if (i == 15) chk("full_hold_before", sbus.core_hold, 1);
         tick();
      end
      sbus.ld_data = 16'hFFFF;
      @(negedge clk);
      chk("full_hold_fall", sbus.core_hold, 0);
      chk("full_ld_ready", sbus.ld_ready, 0);
      tick(); sbus.ld_valid = 0;
      sbus.d_req = 1; sbus.d_we = 0; sbus.d_addr = 16'd0;
      tick(); sbus.d_req = 0;
      @(negedge clk);
      chk("full_ram0_valid", sbus.d_valid, 1);
      chk("full_ram0_data", sbus.d_rdata, 16'hA000);
      sbus.d_req = 1; sbus.d_addr = 16'd15;
      tick(); sbus.d_req = 0;
      @(negedge clk);
      chk("full_ram15_data", sbus.d_rdata, 16'hA00F);
      $display("full load: ram0=%h ram15=%h", 16'hA000, sbus.d_rdata);
      tick();

      // reset in the middle of running fetches
      bus.if_req = 1; bus.if_addr = 16'd2;
      tick(); tick();
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_hold", bus.core_hold, 1);
      chk("mid_rst_if_valid", bus.if_valid, 0);
      chk("mid_rst_instr", bus.instruction, 0);
      chk("mid_rst_oob", bus.oob_err, 0);
      tick(); rst = 1'b0;
      tick();
      @(negedge clk);
      chk("load_ignores_fetch", bus.if_stall, 1);
      ld(16'h7777, 1);
      @(negedge clk);
      chk("reload_grant", bus.if_stall, 0);
      tick(); bus.if_req = 0;
      @(negedge clk);
      chk("reload_fetch2", bus.instruction, 16'h3333);
      bus.d_req = 1; bus.d_addr = 16'd0;
      tick(); bus.d_addr = 16'd1;
      @(negedge clk);
      chk("reload_ram0", bus.d_rdata, 16'h7777);
      tick(); bus.d_req = 0;
      @(negedge clk);
      chk("reload_ram1", bus.d_rdata, 16'h2222);
      $display("after mid-run reset: ram1=%h", bus.d_rdata);
      tick(); tick();

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
